serial_subtractor_8bit: RTL and testbench

Bit-serial subtractor; the counterpart of the team's registered 8-bit ripple adder.
- Captures two operands on a start handshake.
- Computes in1 - in2 - bn_in one bit per clock, LSB first, with a one-hot walking bit mask and a registered borrow.
- Presents a WIDTH+1-bit result with a done flag.
- Used where datapath area matters more than latency; sits beside the adder in the arithmetic unit.

---
 rtl/serial_subtractor_8bit_pkg.sv | 16 +
 rtl/serial_subtractor_8bit_sub_1bit.sv | 14 +
 rtl/serial_subtractor_8bit.sv | 98 +++++++++
 tb/tb_serial_subtractor_8bit.sv | 133 +++++++++++++
 4 files changed

// File: rtl/serial_subtractor_8bit_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encodings, default
// width and the reset value of the walking bit mask.
package serial_subtractor_8bit_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // One-hot bit0: the first bit processed after a capture is the LSB.
  localparam logic [DEFAULT_WIDTH-1:0] MASK_RST = DEFAULT_WIDTH'(1);

endpackage

// File: rtl/serial_subtractor_8bit_sub_1bit.sv
// Combinational 1-bit full subtractor: result = i1 - i2 - bn, with borrow out.
// Mirror of the 1-bit adder cell used by the serial adder.
module sub_1bit (
  input  logic i1,
  input  logic i2,
  input  logic bn,
  output logic result,
  output logic bn_out
);

  assign result = i1 ^ i2 ^ bn;
  assign bn_out = (~i1 & i2) | (~(i1 ^ i2) & bn);

endmodule

// File: rtl/serial_subtractor_8bit.sv
// Bit-serial subtractor: diff = {1'b0,in1} - {1'b0,in2} - bn_in, one bit per
// clock LSB first, reusing a single full-subtractor cell every cycle.
module serial_subtractor_8bit
  import serial_subtractor_8bit_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             bn_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   diff,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MASK_INIT = WIDTH'(MASK_RST);

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] r_q;
  logic             br;

  logic             a_bit;
  logic             b_bit;
  logic             r_bit;
  logic             br_next;
  logic [WIDTH-1:0] r_next;

  // Masked bit select: the one-hot mask picks the operand bit under work.
  assign a_bit  = |(a_q & mask);
  assign b_bit  = |(b_q & mask);
  assign r_next = r_q | (mask & {WIDTH{r_bit}});

  sub_1bit u_sub_1bit (
    .i1     (a_bit),
    .i2     (b_bit),
    .bn     (br),
    .result (r_bit),
    .bn_out (br_next)
  );

  // NOTE: non-blocking assignments throughout, so every register samples the
  // values from before this edge regardless of statement order.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      diff  <= '0;
      ovf   <= 1'b0;
      mask  <= MASK_INIT;
      br    <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      r_q   <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            a_q   <= in1;
            b_q   <= in2;
            br    <= bn_in;
            mask  <= MASK_INIT;
            r_q   <= '0;
            state <= S_RUN;
            busy  <= 1'b1;
            done  <= 1'b0;
          end
        end
        S_RUN: begin
          r_q  <= r_next;
          br   <= br_next;
          mask <= {mask[WIDTH-2:0], mask[WIDTH-1]};
          // MSB edge: br still holds the borrow into the MSB, giving overflow.
          if (mask[WIDTH-1]) begin
            diff  <= {br_next, r_next};
            ovf   <= br ^ br_next;
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor_8bit.sv
// Directed bench for serial_subtractor_8bit: latency, held results, start
// during RUN, back-to-back restart and asynchronous abort.
module tb_serial_subtractor_8bit;
  import serial_subtractor_8bit_pkg::*;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic       start;
  logic [7:0] in1;
  logic [7:0] in2;
  logic       bn_in;
  logic       busy;
  logic       done;
  logic [8:0] diff;
  logic       ovf;

  int checks   = 0;
  int failures = 0;

  serial_subtractor_8bit #(.WIDTH(8)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .start     (start),
    .in1       (in1),
    .in2       (in2),
    .bn_in     (bn_in),
    .busy      (busy),
    .done      (done),
    .diff      (diff),
    .ovf       (ovf)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Capture at edge k, 7 RUN edges with previous result held, result at k+8.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic bn,
                        input logic [8:0] exp_diff, input logic exp_ovf,
                        input logic [8:0] prev_diff);
    @(negedge sys_clk);
    in1 = a; in2 = b; bn_in = bn; start = 1'b1;
    @(posedge sys_clk); #1;
    check("capture_busy_done", {busy, done}, 2'b10);
    @(negedge sys_clk);
    start = 1'b0;
    for (int i = 1; i < 8; i++) begin
      @(posedge sys_clk); #1;
      check("run_busy_done", {busy, done}, 2'b10);
      check("run_diff_hold", diff, prev_diff);
    end
    @(posedge sys_clk); #1;
    check("done_busy_done", {busy, done}, 2'b01);
    check("done_diff", diff, exp_diff);
    check("done_ovf", ovf, exp_ovf);
  endtask

  initial begin
    sys_rst_n = 1'b0;
    start = 1'b0; in1 = '0; in2 = '0; bn_in = 1'b0;
    #1;
    check("reset_outputs", {busy, done, diff, ovf}, 12'h000);
    check("reset_state", dut.state, S_IDLE);
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    check("idle_outputs", {busy, done, diff, ovf}, 12'h000);

    run_op(8'd100, 8'd37, 1'b0, 9'h03F, 1'b0, 9'h000);
    run_op(8'h05,  8'h09, 1'b0, 9'h1FC, 1'b0, 9'h03F);
    run_op(8'h80,  8'h01, 1'b0, 9'h07F, 1'b1, 9'h1FC);
    run_op(8'h00,  8'h00, 1'b1, 9'h1FF, 1'b0, 9'h07F);

    // start held through RUN with different operands: they must be ignored.
    @(negedge sys_clk);
    in1 = 8'h10; in2 = 8'h01; bn_in = 1'b0; start = 1'b1;
    @(posedge sys_clk); #1;
    check("held_capture", {busy, done}, 2'b10);
    @(negedge sys_clk);
    in1 = 8'hFF; in2 = 8'h00;
    for (int i = 1; i < 8; i++) begin
      @(posedge sys_clk); #1;
      check("held_run_busy_done", {busy, done}, 2'b10);
      check("held_run_diff_hold", diff, 9'h1FF);
    end
    @(posedge sys_clk); #1;
    check("held_done_busy_done", {busy, done}, 2'b01);
    check("held_done_diff", diff, 9'h00F);
    check("held_done_ovf", ovf, 1'b0);
    // start still high in DONE: restart at the very next edge.
    @(posedge sys_clk); #1;
    check("restart_busy_done", {busy, done}, 2'b10);
    check("restart_diff_hold", diff, 9'h00F);
    @(negedge sys_clk);
    start = 1'b0;
    for (int i = 1; i < 8; i++) begin
      @(posedge sys_clk); #1;
      check("restart_run", {busy, done}, 2'b10);
    end
    @(posedge sys_clk); #1;
    check("restart_done", {busy, done}, 2'b01);
    check("restart_diff", diff, 9'h0FF);
    check("restart_ovf", ovf, 1'b0);

    // Abort in the 4th RUN cycle with an asynchronous reset.
    @(negedge sys_clk);
    in1 = 8'h20; in2 = 8'h05; bn_in = 1'b0; start = 1'b1;
    @(posedge sys_clk); #1;
    check("abort_capture", {busy, done}, 2'b10);
    @(negedge sys_clk);
    start = 1'b0;
    repeat (3) @(posedge sys_clk);
    #2;
    sys_rst_n = 1'b0;
    #1;
    check("abort_outputs", {busy, done, diff, ovf}, 12'h000);
    check("abort_state", dut.state, S_IDLE);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;

    run_op(8'h03, 8'h01, 1'b0, 9'h002, 1'b0, 9'h000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
